// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - 2-port register-file writeback arbiter with late-result FIFO.
// Optional WB_ARB_BYPASS_EN: a late result arriving at an empty FIFO goes straight to a free port.
module wb_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int LATE_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 pipe_valid_i,
  input  logic [1:0][4:0]            pipe_addr_i,
  input  logic [1:0][DATA_WIDTH-1:0] pipe_data_i,
  input  logic                       late_valid_i,
  output logic                       late_ready_o,
  input  logic [4:0]                 late_addr_i,
  input  logic [DATA_WIDTH-1:0]      late_data_i,
  output logic [1:0]                 w_en_o,
  output logic [1:0][4:0]            w_addr_o,
  output logic [1:0][DATA_WIDTH-1:0] w_data_o,
  output logic [31:0]                late_pending_o
);
  localparam int PW = $clog2(LATE_DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]            fifo_addr_q [LATE_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_q [LATE_DEPTH];
  logic [PW-1:0]         rd_ptr_q, wr_ptr_q, rd_nxt;
  logic [CW-1:0]         count_q, count_d;

  logic [1:0]                 w_en_q, w_en_d, w_late_q, w_late_d;
  logic [1:0][4:0]            w_addr_q, w_addr_d;
  logic [1:0][DATA_WIDTH-1:0] w_data_q, w_data_d;

  logic act0, act1, same, free0, free1, any_free;
  logic pop0, pop1, push, byp;
  logic [CW-1:0] n_pop;

  assign act0     = pipe_valid_i[0] && (pipe_addr_i[0] != 5'd0);
  assign act1     = pipe_valid_i[1] && (pipe_addr_i[1] != 5'd0);
  assign same     = act0 && act1 && (pipe_addr_i[0] == pipe_addr_i[1]);
  assign free0    = !act0;
  assign free1    = !act1;
  assign any_free = free0 || free1;
  assign rd_nxt   = rd_ptr_q + 1'b1;

  // Ready only looks at registered occupancy, so a full FIFO refuses even while draining.
  assign late_ready_o = (count_q != CW'(LATE_DEPTH));
  assign pop0 = (count_q != '0) && any_free;
  assign pop1 = free0 && free1 && (count_q >= CW'(2));

`ifdef WB_ARB_BYPASS_EN
  assign byp = (count_q == '0) && late_valid_i && late_ready_o && (late_addr_i != 5'd0) && any_free;
`else
  assign byp = 1'b0;
`endif

  assign push  = late_valid_i && late_ready_o && (late_addr_i != 5'd0) && !byp;
  assign n_pop = CW'(pop0) + CW'(pop1);
  assign count_d = count_q + CW'(push) - n_pop;

  always_comb begin
    w_en_d   = '0;
    w_late_d = '0;
    w_addr_d = '0;
    w_data_d = '0;
    // Port 0: lane 0 unless the younger lane overwrites the same register.
    if (act0 && !same) begin
      w_en_d[0] = 1'b1; w_addr_d[0] = pipe_addr_i[0]; w_data_d[0] = pipe_data_i[0];
    end else if (free0 && pop0) begin
      w_en_d[0] = 1'b1; w_late_d[0] = 1'b1;
      w_addr_d[0] = fifo_addr_q[rd_ptr_q]; w_data_d[0] = fifo_data_q[rd_ptr_q];
    end else if (free0 && byp) begin
      w_en_d[0] = 1'b1; w_late_d[0] = 1'b1;
      w_addr_d[0] = late_addr_i; w_data_d[0] = late_data_i;
    end
    if (act1) begin
      w_en_d[1] = 1'b1; w_addr_d[1] = pipe_addr_i[1]; w_data_d[1] = pipe_data_i[1];
    end else if (free0 && pop1) begin
      w_en_d[1] = 1'b1; w_late_d[1] = 1'b1;
      w_addr_d[1] = fifo_addr_q[rd_nxt]; w_data_d[1] = fifo_data_q[rd_nxt];
    end else if (!free0 && pop0) begin
      w_en_d[1] = 1'b1; w_late_d[1] = 1'b1;
      w_addr_d[1] = fifo_addr_q[rd_ptr_q]; w_data_d[1] = fifo_data_q[rd_ptr_q];
    end else if (!free0 && byp) begin
      w_en_d[1] = 1'b1; w_late_d[1] = 1'b1;
      w_addr_d[1] = late_addr_i; w_data_d[1] = late_data_i;
    end
  end

  always_comb begin
    late_pending_o = '0;
    for (int i = 0; i < LATE_DEPTH; i++) begin
      if (CW'(i) < count_q) late_pending_o[fifo_addr_q[rd_ptr_q + PW'(i)]] = 1'b1;
    end
    for (int p = 0; p < 2; p++) begin
      if (w_en_q[p] && w_late_q[p]) late_pending_o[w_addr_q[p]] = 1'b1;
    end
    late_pending_o[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      w_en_q   <= '0;
      w_late_q <= '0;
      w_addr_q <= '0;
      w_data_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_q + PW'(n_pop);
      wr_ptr_q <= wr_ptr_q + PW'(push);
      count_q  <= count_d;
      w_en_q   <= w_en_d;
      w_late_q <= w_late_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= late_addr_i;
      fifo_data_q[wr_ptr_q] <= late_data_i;
    end
  end

  assign w_en_o   = w_en_q;
  assign w_addr_o = w_addr_q;
  assign w_data_o = w_data_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - directed self-checking bench for wb_port_arbiter.
module tb_wb_port_arbiter;
  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       pipe_valid;
  logic [1:0][4:0]  pipe_addr;
  logic [1:0][31:0] pipe_data;
  logic             late_valid;
  logic             late_ready;
  logic [4:0]       late_addr;
  logic [31:0]      late_data;
  logic [1:0]       w_en;
  logic [1:0][4:0]  w_addr;
  logic [1:0][31:0] w_data;
  logic [31:0]      pending;

  int checks = 0;
  int failures = 0;

  wb_port_arbiter #(.DATA_WIDTH(32), .LATE_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_valid_i(pipe_valid), .pipe_addr_i(pipe_addr), .pipe_data_i(pipe_data),
    .late_valid_i(late_valid), .late_ready_o(late_ready),
    .late_addr_i(late_addr), .late_data_i(late_data),
    .w_en_o(w_en), .w_addr_o(w_addr), .w_data_o(w_data),
    .late_pending_o(pending)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lanes(input logic [1:0] v, input logic [4:0] a0, input logic [31:0] d0,
                           input logic [4:0] a1, input logic [31:0] d1);
    pipe_valid = v;
    pipe_addr[0] = a0; pipe_data[0] = d0;
    pipe_addr[1] = a1; pipe_data[1] = d1;
  endtask

  task automatic set_late(input logic v, input logic [4:0] a, input logic [31:0] d);
    late_valid = v; late_addr = a; late_data = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_lanes(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    set_late(1'b0, 5'd0, 32'd0);
    step(); step();
    rst_n = 1'b1;
    checks++;
    if (w_addr !== '0 || w_data !== '0) begin
      failures++; $display("FAIL reset_addr_data: addr=%h data=%h expected 0", w_addr, w_data);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (w_en !== 2'b00 || late_ready !== 1'b1 || pending !== 32'h0) begin
        failures++;
        $display("FAIL reset_idle[%0d]: w_en=%b ready=%b pending=%h expected 00/1/0", c, w_en, late_ready, pending);
      end
    end
  endtask

  task automatic test_lanes();
    set_lanes(2'b11, 5'd5, 32'h11, 5'd6, 32'h22);
    step();
    checks++;
    if (w_en !== 2'b11 || w_addr[0] !== 5'd5 || w_addr[1] !== 5'd6 ||
        w_data[0] !== 32'h11 || w_data[1] !== 32'h22) begin
      failures++;
      $display("FAIL lanes_both: en=%b a0=%0d a1=%0d d0=%h d1=%h expected 11/5/6/11/22",
               w_en, w_addr[0], w_addr[1], w_data[0], w_data[1]);
    end
    set_lanes(2'b11, 5'd5, 32'h11, 5'd0, 32'h22);
    step();
    checks++;
    if (w_en !== 2'b01 || w_addr[0] !== 5'd5 || w_data[0] !== 32'h11) begin
      failures++;
      $display("FAIL lanes_addr0: en=%b a0=%0d d0=%h expected 01/5/11", w_en, w_addr[0], w_data[0]);
    end
    set_lanes(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    step();
  endtask

  task automatic test_same_addr();
    set_lanes(2'b11, 5'd7, 32'hAA, 5'd7, 32'hBB);
    step();
    checks++;
    if (w_en !== 2'b10 || w_addr[1] !== 5'd7 || w_data[1] !== 32'hBB) begin
      failures++;
      $display("FAIL same_addr: en=%b a1=%0d d1=%h expected 10/7/BB", w_en, w_addr[1], w_data[1]);
    end
    set_lanes(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    step();
  endtask

  task automatic test_fifo_fill_drain();
    set_lanes(2'b11, 5'd20, 32'h200, 5'd21, 32'h210);
    for (int k = 1; k <= 4; k++) begin
      set_late(1'b1, 5'(k), 32'h100 + k);
      step();
    end
    checks++;
    if (late_ready !== 1'b0 || pending !== 32'h1E) begin
      failures++; $display("FAIL fill_full: ready=%b pending=%h expected 0/1e", late_ready, pending);
    end
    set_late(1'b1, 5'd8, 32'h108);
    step();
    checks++;
    if (late_ready !== 1'b0 || pending !== 32'h1E || w_en !== 2'b11 || w_addr[0] !== 5'd20) begin
      failures++;
      $display("FAIL fill_held: ready=%b pending=%h en=%b a0=%0d expected 0/1e/11/20",
               late_ready, pending, w_en, w_addr[0]);
    end
    set_late(1'b0, 5'd0, 32'd0);
    set_lanes(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    step();
    checks++;
    if (w_en !== 2'b11 || w_addr[0] !== 5'd1 || w_addr[1] !== 5'd2 || w_data[0] !== 32'h101 ||
        w_data[1] !== 32'h102 || late_ready !== 1'b1 || pending !== 32'h1E) begin
      failures++;
      $display("FAIL drain_first: en=%b a0=%0d a1=%0d d0=%h d1=%h ready=%b pending=%h expected 11/1/2/101/102/1/1e",
               w_en, w_addr[0], w_addr[1], w_data[0], w_data[1], late_ready, pending);
    end
    step();
    checks++;
    if (w_en !== 2'b11 || w_addr[0] !== 5'd3 || w_addr[1] !== 5'd4 || w_data[0] !== 32'h103 ||
        w_data[1] !== 32'h104 || pending !== 32'h18) begin
      failures++;
      $display("FAIL drain_second: en=%b a0=%0d a1=%0d d0=%h d1=%h pending=%h expected 11/3/4/103/104/18",
               w_en, w_addr[0], w_addr[1], w_data[0], w_data[1], pending);
    end
    step();
    checks++;
    if (w_en !== 2'b00 || pending !== 32'h0 || late_ready !== 1'b1) begin
      failures++; $display("FAIL drain_done: en=%b pending=%h ready=%b expected 00/0/1", w_en, pending, late_ready);
    end
  endtask

  task automatic test_drain_port1();
    set_lanes(2'b11, 5'd20, 32'h1, 5'd21, 32'h2);
    set_late(1'b1, 5'd9, 32'h99);
    step();
    checks++;
    if (pending !== 32'h200) begin
      failures++; $display("FAIL port1_queued: pending=%h expected 200", pending);
    end
    set_late(1'b0, 5'd0, 32'd0);
    set_lanes(2'b01, 5'd10, 32'hA0, 5'd0, 32'd0);
    step();
    checks++;
    if (w_en !== 2'b11 || w_addr[0] !== 5'd10 || w_data[0] !== 32'hA0 ||
        w_addr[1] !== 5'd9 || w_data[1] !== 32'h99 || pending !== 32'h200) begin
      failures++;
      $display("FAIL port1_drain: en=%b a0=%0d d0=%h a1=%0d d1=%h pending=%h expected 11/10/a0/9/99/200",
               w_en, w_addr[0], w_data[0], w_addr[1], w_data[1], pending);
    end
    set_lanes(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    step();
    checks++;
    if (w_en !== 2'b00 || pending !== 32'h0) begin
      failures++; $display("FAIL port1_clear: en=%b pending=%h expected 00/0", w_en, pending);
    end
  endtask

  task automatic test_bypass();
    logic [1:0]  exp_en1, exp_en2;
    logic [31:0] exp_p1, exp_p2;
`ifdef WB_ARB_BYPASS_EN
    exp_en1 = 2'b01; exp_en2 = 2'b00; exp_p1 = 32'h1000; exp_p2 = 32'h0;
`else
    exp_en1 = 2'b00; exp_en2 = 2'b01; exp_p1 = 32'h1000; exp_p2 = 32'h1000;
`endif
    set_late(1'b1, 5'd12, 32'h5A);
    step();
    set_late(1'b0, 5'd0, 32'd0);
    checks++;
    if (w_en !== exp_en1 || pending !== exp_p1 ||
        (exp_en1[0] && (w_addr[0] !== 5'd12 || w_data[0] !== 32'h5A))) begin
      failures++;
      $display("FAIL bypass_n1: en=%b pending=%h a0=%0d d0=%h expected en=%b pending=%h",
               w_en, pending, w_addr[0], w_data[0], exp_en1, exp_p1);
    end
    step();
    checks++;
    if (w_en !== exp_en2 || pending !== exp_p2 ||
        (exp_en2[0] && (w_addr[0] !== 5'd12 || w_data[0] !== 32'h5A))) begin
      failures++;
      $display("FAIL bypass_n2: en=%b pending=%h a0=%0d d0=%h expected en=%b pending=%h",
               w_en, pending, w_addr[0], w_data[0], exp_en2, exp_p2);
    end
    step();
    checks++;
    if (w_en !== 2'b00 || pending !== 32'h0) begin
      failures++; $display("FAIL bypass_n3: en=%b pending=%h expected 00/0", w_en, pending);
    end
  endtask

  task automatic test_reset_midop();
    set_lanes(2'b11, 5'd20, 32'h1, 5'd21, 32'h2);
    set_late(1'b1, 5'd3, 32'h33);
    step();
    set_late(1'b1, 5'd0, 32'h44);
    step();
    checks++;
    if (pending !== 32'h8) begin
      failures++; $display("FAIL addr0_push: pending=%h expected 8", pending);
    end
    set_late(1'b1, 5'd4, 32'h44);
    step();
    set_late(1'b0, 5'd0, 32'd0);
    set_lanes(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if (pending !== 32'h0 || late_ready !== 1'b1 || w_en !== 2'b00) begin
      failures++;
      $display("FAIL midop_reset: pending=%h ready=%b en=%b expected 0/1/00", pending, late_ready, w_en);
    end
    step();
    checks++;
    if (w_en !== 2'b00 || pending !== 32'h0) begin
      failures++; $display("FAIL midop_after: en=%b pending=%h expected 00/0", w_en, pending);
    end
  endtask

  initial begin
    test_reset();
    test_lanes();
    test_same_addr();
    test_fifo_fill_drain();
    test_drain_port1();
    test_bypass();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
